// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared constants and access-size type for the pipelined memory
package params_pkg;

  localparam int MEM_SIZE   = 1024;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } access_size_t;

  // The unused fourth encoding is treated as a full word.
  function automatic logic [2:0] size_bytes(access_size_t s);
    case (s)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// rtl/rsp_fifo.sv - synchronous response FIFO, power-of-two depth, zeroed output when empty
module rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign pop_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop_valid & pop_ready;
  assign do_push   = push_valid & (~full | do_pop);
  assign pop_data  = pop_valid ? store[rd_ptr] : '0;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_valid && full));

endmodule

// File: rtl/pipelined_mem.sv
// rtl/pipelined_mem.sv - fixed-latency byte-addressed memory with in-order read responses
module pipelined_mem
  import params_pkg::*;
#(
  parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int LATENCY    = 10,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic                  req_is_instr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  access_size_t          req_size_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_is_instr_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o
);

  localparam int ACC   = LATENCY / 2;
  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int RSP_W = DATA_WIDTH + 2;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  is_instr;
    logic                  err;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    access_size_t          size;
    logic [DATA_WIDTH-1:0] rdata;
  } stage_t;

  stage_t           pipe [LATENCY];
  stage_t           fwd  [LATENCY];
  logic [7:0]       mem  [MEM_SIZE] = '{default: 8'h00};
  logic [CNT_W-1:0] outstanding;
  logic             accept_rd;
  logic             pop;
  logic             acc_err;
  logic             acc_wr;
  logic [2:0]       acc_nbytes;
  logic [31:0]      acc_last;
  logic [IDX_W-1:0] acc_idx;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic [RSP_W-1:0] rsp_word;

  assign req_ready_o = (outstanding < CNT_W'(RSP_DEPTH));
  assign accept_rd   = req_valid_i & req_ready_o & ~req_we_i;
  assign pop         = rsp_valid_o & rsp_ready_i;

  // fwd[k] is what stage k hands to stage k+1; only the access stage alters it.
  always_comb begin
    acc_nbytes = size_bytes(pipe[ACC].size);
    acc_last   = 32'(pipe[ACC].addr) + 32'(acc_nbytes) - 32'd1;
    acc_err    = (acc_nbytes == 3'd2 && pipe[ACC].addr[0])
              || (acc_nbytes == 3'd4 && pipe[ACC].addr[1:0] != 2'b00)
              || (acc_last >= 32'(MEM_SIZE));
    acc_idx    = pipe[ACC].addr[IDX_W-1:0];
    acc_rdata  = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < acc_nbytes && !acc_err) acc_rdata[8*i +: 8] = mem[acc_idx + IDX_W'(i)];
    end
    acc_wr = pipe[ACC].valid & pipe[ACC].we & ~acc_err;
    for (int k = 0; k < LATENCY; k++) fwd[k] = pipe[k];
    fwd[ACC].err   = acc_err;
    fwd[ACC].rdata = acc_rdata;
    fwd[ACC].valid = pipe[ACC].valid & ~pipe[ACC].we;
  end

  // A write reaching the access stage on a reset edge is dropped with the rest of the pipe.
  always_ff @(posedge clk_i) begin
    if (acc_wr && !rst_i) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < acc_nbytes) mem[acc_idx + IDX_W'(i)] <= pipe[ACC].wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
      outstanding <= '0;
    end else begin
      pipe[0] <= '{valid:    req_valid_i & req_ready_o,
                   we:       req_we_i,
                   is_instr: req_is_instr_i,
                   err:      1'b0,
                   addr:     req_addr_i,
                   wdata:    req_wdata_i,
                   size:     req_size_i,
                   rdata:    '0};
      for (int k = 1; k < LATENCY; k++) pipe[k] <= fwd[k-1];
      if (accept_rd && !pop)      outstanding <= outstanding + CNT_W'(1);
      else if (!accept_rd && pop) outstanding <= outstanding - CNT_W'(1);
    end
  end

  rsp_fifo #(
    .WIDTH(RSP_W),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_valid (fwd[LATENCY-1].valid),
    .push_data  ({fwd[LATENCY-1].is_instr, fwd[LATENCY-1].err, fwd[LATENCY-1].rdata}),
    .pop_ready  (rsp_ready_i),
    .pop_valid  (rsp_valid_o),
    .pop_data   (rsp_word)
  );

  assign {rsp_is_instr_o, rsp_err_o, rsp_data_o} = rsp_word;

endmodule

// File: doc/pipelined_mem.md
PIPELINED_MEM -- requirements
Module: pipelined_mem

Interface
REQ-001 Parameter MEM_SIZE, params_pkg::MEM_SIZE, memory size in bytes.
REQ-002 Parameter ADDR_WIDTH, params_pkg::ADDR_WIDTH, byte-address width.
REQ-003 Parameter DATA_WIDTH, params_pkg::DATA_WIDTH (32), data width.
REQ-004 Parameter LATENCY, 10, cycles from request acceptance to earliest response; legal range >= 2.
REQ-005 Parameter RSP_DEPTH, 4, response FIFO entries and maximum outstanding reads; power of 2, >= 2.
REQ-006 clk_i  input  1  single clock; all state on rising edge.
REQ-007 rst_i  input  1  reset, synchronous, active-high.
REQ-008 req_valid_i  input  1  request present.
REQ-009 req_ready_o  output  1  request can be accepted.
REQ-010 req_we_i  input  1  1 = write, 0 = read.
REQ-011 req_is_instr_i  input  1  request tag, returned with read response.
REQ-012 req_addr_i  input  ADDR_WIDTH  byte address.
REQ-013 req_wdata_i  input  DATA_WIDTH  write data, little-endian, LSB-aligned.
REQ-014 req_size_i  input  access_size_t  BYTE, HALF or WORD.
REQ-015 rsp_valid_o  output  1  read response present.
REQ-016 rsp_ready_i  input  1  consumer accepts response.
REQ-017 rsp_is_instr_o  output  1  tag of the responding read.
REQ-018 rsp_err_o  output  1  responding read was misaligned or out of range.
REQ-019 rsp_data_o  output  DATA_WIDTH  read data, zero-extended.

Function
REQ-020 A request SHALL be accepted on a rising edge where req_valid_i & req_ready_o; all request fields are sampled at that edge.
REQ-021 Accepted requests SHALL travel an in-order pipeline of LATENCY stages carrying valid, we, is_instr, addr, wdata and size.
REQ-022 Memory access SHALL occur at stage ACC = LATENCY/2 (integer division). Reads sample memory combinationally in that stage; writes commit at the end of that cycle.
REQ-023 A read accepted after a write to an overlapping byte SHALL return the new data, including back-to-back acceptance.
REQ-024 A read accepted at edge t SHALL enter the response FIFO at edge t+LATENCY. If the FIFO is empty, rsp_valid_o SHALL be 1 in the cycle after that edge.
REQ-025 Writes SHALL produce no response. Stage valid SHALL be cleared for a write after stage ACC.
REQ-026 Access size SHALL select little-endian byte lanes: BYTE = [7:0], HALF = [15:0], WORD = [31:0]. Reads SHALL zero-extend; writes SHALL modify only the selected bytes.
REQ-027 Error condition: HALF with addr[0] != 0; WORD with addr[1:0] != 0; or addr + bytes - 1 >= MEM_SIZE.
REQ-028 On the error condition, an errored read SHALL return rsp_data_o = 0 with rsp_err_o = 1, and an errored write SHALL leave memory unchanged.
REQ-029 An outstanding counter (width clog2(RSP_DEPTH)+1) SHALL increment on read acceptance and decrement on response pop (rsp_valid_o & rsp_ready_i). Simultaneous increment and decrement SHALL leave it unchanged.
REQ-030 req_ready_o SHALL be 1 iff outstanding < RSP_DEPTH. Writes are accepted under the same condition but SHALL NOT change the counter.
REQ-031 The response FIFO SHALL never overflow. rsp_valid_o SHALL equal FIFO non-empty, and response outputs SHALL hold stable while rsp_valid_o & !rsp_ready_i.
REQ-032 FIFO pointers SHALL wrap modulo RSP_DEPTH. A simultaneous push and pop on a full or empty FIFO SHALL preserve ordering and occupancy.

Reset
REQ-033 While rst_i = 1 at an edge, all stage valids, the outstanding counter and the FIFO pointers SHALL clear. After that edge: rsp_valid_o = 0, rsp_err_o = 0, rsp_is_instr_o = 0, rsp_data_o = 0, req_ready_o = 1.
REQ-034 Reset mid-operation SHALL discard all in-flight requests. Writes not yet at stage ACC SHALL NOT commit.
REQ-035 Memory contents SHALL NOT be affected by reset; they SHALL be zero-initialised at time 0.

Structure
REQ-036 access_size_t (BYTE, HALF, WORD) and the MEM_SIZE, ADDR_WIDTH and DATA_WIDTH constants SHALL live in params_pkg.
REQ-037 The response buffer SHALL be a separate parametrised synchronous FIFO sub-module, rsp_fifo.
REQ-038 An assertion SHALL flag a FIFO push when the FIFO is full.

Verification (LATENCY=10, RSP_DEPTH=4)
REQ-039 WORD write 0xDEADBEEF to addr 0x10, then WORD read of 0x10 on the next cycle -> rsp_data_o = 0xDEADBEEF, rsp_err_o = 0, rsp_valid_o 10 cycles after read acceptance.
REQ-040 BYTE write 0xAA to addr 0x11 over the above, then HALF read of 0x10 -> rsp_data_o = 0x0000AAEF.
REQ-041 rsp_ready_i = 0 with 5 back-to-back reads -> 4 accepted, req_ready_o = 0. Then rsp_ready_i = 1 -> 4 responses in order, and the 5th is accepted the cycle after the first pop.
REQ-042 WORD read at addr 0x13 -> rsp_err_o = 1, rsp_data_o = 0. A WORD write at MEM_SIZE-2 -> memory unchanged on read-back.
REQ-043 rst_i asserted 3 cycles after a write to 0x20 -> a read of 0x20 after reset returns its prior value; no rsp_valid_o from pre-reset reads.
